// File: rtl/result_readout_buffer_pkg.sv
// Shared NPU parameters for the result readout path: output-count derivation,
// index width and the readout FSM state encoding.
package result_readout_buffer_pkg;

    localparam int DATA_W = 32;

    function automatic int calc_num_out(input int in_h, input int in_w,
                                        input int wt_h, input int wt_w);
        return (in_h - wt_h + 1) * (in_w - wt_w + 1);
    endfunction

    function automatic int calc_idx_w(input int num_out);
        return $clog2(num_out + 1);
    endfunction

    // Values for the default 9x9 feature map convolved with a 3x3 kernel.
    localparam int NUM_OUT = calc_num_out(9, 9, 3, 3);
    localparam int IDX_W   = calc_idx_w(NUM_OUT);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/result_readout_buffer_word_select.sv
// Picks one ACC_WIDTH element out of the stored result vector and
// sign-extends it to a 32-bit bus word.
module result_word_select
    import result_readout_buffer_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_OUT   = 49,
    parameter int IDX_W     = 6
) (
    input  logic [ACC_WIDTH*NUM_OUT-1:0] results_vec_i,
    input  logic [IDX_W-1:0]             index_i,
    output logic [DATA_W-1:0]            word_o
);

    logic [ACC_WIDTH-1:0] elem;

    // NOTE: the default assignment before the loop keeps this block latch-free.
    always_comb begin
        elem = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (index_i == IDX_W'(k)) begin
                elem = results_vec_i[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign word_o = DATA_W'(signed'(elem));

endmodule

// File: rtl/result_readout_buffer.sv
// Captures a full result vector from the compute array and streams it out one
// sign-extended element per accepted read towards the AXI side.
module result_readout_buffer
    import result_readout_buffer_pkg::*;
#(
    parameter int  ACC_WIDTH     = 16,
    parameter int  INPUT_WIDTH   = 9,
    parameter int  INPUT_HEIGHT  = 9,
    parameter int  WEIGHT_WIDTH  = 3,
    parameter int  WEIGHT_HEIGHT = 3,
    localparam int NUM_OUT       = calc_num_out(INPUT_HEIGHT, INPUT_WIDTH,
                                                WEIGHT_HEIGHT, WEIGHT_WIDTH),
    localparam int IDX_W         = calc_idx_w(NUM_OUT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ACC_WIDTH*NUM_OUT-1:0] results_in,
    input  logic                         results_valid,
    input  logic                         read_enable,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_valid,
    output logic                         result_buffer_ready,
    output logic                         readout_done,
    output logic                         overrun,
    output logic [IDX_W-1:0]             read_index
);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         done_q, done_d;
    logic                         ovr_q, ovr_d;
    logic [ACC_WIDTH*NUM_OUT-1:0] results_q;
    logic                         capture;
    logic                         last_elem;
    logic [DATA_W-1:0]            word;

    assign capture   = (state_q == ST_IDLE) && results_valid && !reset;
    assign last_elem = (idx_q == IDX_W'(NUM_OUT - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (results_valid) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                // A new vector while streaming is dropped, only flagged.
                if (results_valid) begin
                    ovr_d = 1'b1;
                end
                if (read_enable) begin
                    if (last_elem) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // NOTE: the data store has no reset; it is only observable after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            results_q <= results_in;
        end
    end

    result_word_select #(
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_OUT   (NUM_OUT),
        .IDX_W     (IDX_W)
    ) u_word_select (
        .results_vec_i (results_q),
        .index_i       (idx_q),
        .word_o        (word)
    );

    assign data_valid          = (state_q == ST_STREAM);
    assign data_out            = data_valid ? word : '0;
    assign result_buffer_ready = (state_q == ST_IDLE);
    assign readout_done        = done_q;
    assign overrun             = ovr_q;
    assign read_index          = idx_q;

endmodule

// File: tb/tb_result_readout_buffer.sv
// Self-checking bench for result_readout_buffer: directed scenarios plus random
// read/valid traffic, compared against a queue-style reference of the stream.
module tb_result_readout_buffer;

    localparam int ACC = 16;
    localparam int N   = 49;
    localparam int IW  = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [ACC*N-1:0] results_in;
    logic             results_valid;
    logic             read_enable;
    logic [31:0]      data_out;
    logic             data_valid;
    logic             result_buffer_ready;
    logic             readout_done;
    logic             overrun;
    logic [IW-1:0]    read_index;

    int total = 0;
    int bad   = 0;

    logic [ACC-1:0] nv[N];
    logic [ACC-1:0] m_vec[N];
    bit             m_busy;
    bit             m_done;
    bit             m_ovr;
    int             m_pos;

    result_readout_buffer dut (
        .clk                 (clk),
        .reset               (reset),
        .results_in          (results_in),
        .results_valid       (results_valid),
        .read_enable         (read_enable),
        .data_out            (data_out),
        .data_valid          (data_valid),
        .result_buffer_ready (result_buffer_ready),
        .readout_done        (readout_done),
        .overrun             (overrun),
        .read_index          (read_index)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [ACC-1:0] v);
        return {{(32-ACC){v[ACC-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ready", 32'(result_buffer_ready), 32'(!m_busy));
        check("valid", 32'(data_valid), 32'(m_busy));
        check("done", 32'(readout_done), 32'(m_done));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_busy) begin
            check("data_out", data_out, sext(m_vec[m_pos]));
            check("read_index", 32'(read_index), 32'(m_pos));
        end
    endtask

    // One clock: drive inputs, advance the reference stream, then compare.
    task automatic step(input bit rst, input bit rv, input bit re);
        reset         = rst;
        results_valid = rv;
        read_enable   = re;
        for (int k = 0; k < N; k++) results_in[k*ACC +: ACC] = nv[k];
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_done = 0; m_ovr = 0; m_pos = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (rv) m_ovr = 1;
                if (re) begin
                    if (m_pos == N - 1) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (rv) begin
                m_vec  = nv;
                m_busy = 1;
                m_pos  = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic new_vec();
        for (int k = 0; k < N; k++) nv[k] = ACC'($urandom);
    endtask

    task automatic advance_to(input int p);
        int n = 0;
        while (m_busy && m_pos < p && n < 100) begin
            step(0, 0, 1);
            n++;
        end
        check("advance_idx", 32'(read_index), 32'(p));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (m_busy && n < 1000) begin
            if (rnd) step(0, 1'($urandom), 1'($urandom));
            else     step(0, 0, 1);
            n++;
        end
        check("drain_end", 32'(data_valid), 32'(0));
    endtask

    initial begin
        int cycles;
        reset = 1'b1; results_valid = 1'b0; read_enable = 1'b0; results_in = '0;
        for (int k = 0; k < N; k++) nv[k] = '0;

        // Reset state
        step(1, 0, 0);
        step(1, 0, 1);
        check("rst_data_out", data_out, 32'h0);
        check("rst_read_index", 32'(read_index), 32'h0);

        // Ramp 1..49 with read_enable held high
        for (int k = 0; k < N; k++) nv[k] = ACC'(k + 1);
        step(0, 1, 1);
        check("ramp_first", data_out, 32'd1);
        cycles = 0;
        while (data_valid && cycles < 60) begin
            step(0, 0, 1);
            cycles++;
        end
        check("ramp_cycles", 32'(cycles), 32'd49);
        check("ramp_done", 32'(readout_done), 32'd1);
        step(0, 0, 1);

        // Sign extension and read_enable gaps
        new_vec();
        nv[3] = 16'hFFFF;
        nv[4] = 16'h7FFF;
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("hold_idx", 32'(read_index), 32'd1);
        step(0, 0, 1);
        step(0, 0, 1);
        check("neg_ext", data_out, 32'hFFFF_FFFF);
        step(0, 0, 1);
        check("pos_ext", data_out, 32'h0000_7FFF);

        // Overrun at index 10; remainder still from the first vector
        advance_to(10);
        new_vec();
        step(0, 1, 1);
        check("ovr_set", 32'(overrun), 32'd1);
        new_vec();
        drain(1'b1);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-stream at index 20, with competing valid/read inputs
        new_vec();
        step(0, 1, 0);
        advance_to(20);
        step(1, 1, 1);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_idx", 32'(read_index), 32'd0);
        check("abort_done", 32'(readout_done), 32'd0);
        check("abort_ovr", 32'(overrun), 32'd0);
        step(0, 0, 0);
        new_vec();
        step(0, 1, 1);
        check("fresh_first", data_out, sext(nv[0]));
        drain(1'b0);

        // Capture in the readout_done cycle
        check("done_cycle", 32'(readout_done), 32'd1);
        new_vec();
        step(0, 1, 1);
        check("back2back_ovr", 32'(overrun), 32'd0);
        check("back2back_first", data_out, sext(nv[0]));
        drain(1'b0);

        // Random traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(0, 0, 1'($urandom));
            new_vec();
            step(0, 1, 1'($urandom));
            new_vec();
            drain(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
